// File: rtl/nl_eject_vc_scheduler.sv
// nl_eject_vc_scheduler
//   Ejection-side VC buffering and arbitration between a router's local exit
//   port and the node sink. Each exit VC has its own FIFO. A packet-atomic
//   round-robin arbiter grants the single ejection channel to one VC at a time.
//   One credit is returned to the router for every flit dequeued.
//
// Optional feature: define NL_EJECT_STATS_EN to add the pkt_count,
// stall_cycles and bubble_cycles statistics outputs.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_vc/in_tail/in_data     flit from router exit (in_vc one-hot)
//   credit_valid/credit_vc             registered credit return (binary VC)
//   out_valid/out_ready/out_vc/out_tail/out_data  ejection handshake
//   err_overflow    sticky: flit dropped at a full VC FIFO
//   err_vc          sticky: flit dropped for a non-one-hot in_vc
module nl_eject_vc_scheduler #(
  parameter int unsigned NUM_VCS   = 2,
  parameter int unsigned FLIT_W    = 64,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [NUM_VCS-1:0]         in_vc,
  input  logic                       in_tail,
  input  logic [FLIT_W-1:0]          in_data,
  output logic                       credit_valid,
  output logic [$clog2(NUM_VCS)-1:0] credit_vc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_VCS)-1:0] out_vc,
  output logic                       out_tail,
  output logic [FLIT_W-1:0]          out_data,
  output logic                       err_overflow,
  output logic                       err_vc
`ifdef NL_EJECT_STATS_EN
  ,
  output logic [31:0]                pkt_count [NUM_VCS],
  output logic [31:0]                stall_cycles,
  output logic [31:0]                bubble_cycles
`endif
);

  localparam int unsigned VCW = $clog2(NUM_VCS);
  localparam int unsigned PW  = $clog2(BUF_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned EW  = FLIT_W + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  logic [EW-1:0]      mem_q [NUM_VCS][BUF_DEPTH];
  logic [PW-1:0]      wptr_q [NUM_VCS];
  logic [PW-1:0]      wptr_d [NUM_VCS];
  logic [PW-1:0]      rptr_q [NUM_VCS];
  logic [PW-1:0]      rptr_d [NUM_VCS];
  logic [CW-1:0]      cnt_q  [NUM_VCS];
  logic [CW-1:0]      cnt_d  [NUM_VCS];
  logic [NUM_VCS-1:0] nonempty;
  logic [NUM_VCS-1:0] full;
  logic [NUM_VCS-1:0] enq_v;
  logic [NUM_VCS-1:0] deq_v;

  state_e             state_q, state_d;
  logic [VCW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [VCW-1:0]     lock_vc_q, lock_vc_d;
  logic [VCW-1:0]     grant;
  logic               offer;
  logic               xfer;
  logic [EW-1:0]      head;
  int unsigned        scan_idx;
  logic               scan_found;

  logic               vc_onehot;
  logic [VCW-1:0]     in_idx;
  logic               enq_ok;
  logic               enq_drop_full;

  logic               credit_valid_q, credit_valid_d;
  logic [VCW-1:0]     credit_vc_q, credit_vc_d;
  logic               err_overflow_q, err_overflow_d;
  logic               err_vc_q, err_vc_d;

  // FIFO status as seen at the start of the cycle
  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      nonempty[v] = (cnt_q[v] != '0);
      full[v]     = (cnt_q[v] == CW'(BUF_DEPTH));
    end
  end

  // Arbitration FSM: round-robin in IDLE, wormhole lock in LOCKED
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_vc_d  = lock_vc_q;
    grant      = '0;
    offer      = 1'b0;
    scan_idx   = 0;
    scan_found = 1'b0;
    unique case (state_q)
      IDLE: begin
        for (int unsigned i = 1; i <= NUM_VCS; i++) begin
          scan_idx = (32'(rr_ptr_q) + i) % NUM_VCS;
          if (!scan_found && nonempty[scan_idx]) begin
            grant      = VCW'(scan_idx);
            scan_found = 1'b1;
          end
        end
        offer = scan_found;
        if (offer) begin
          if (out_ready && head[FLIT_W]) begin
            rr_ptr_d = grant;
          end else begin
            // Multi-flit head or stalled offer: pin the VC so the offer stays stable
            lock_vc_d = grant;
            state_d   = LOCKED;
          end
        end
      end
      LOCKED: begin
        grant = lock_vc_q;
        offer = nonempty[lock_vc_q];
        if (offer && out_ready && head[FLIT_W]) begin
          rr_ptr_d = lock_vc_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign head      = mem_q[grant][rptr_q[grant]];
  assign xfer      = offer && out_ready;
  assign out_valid = offer;
  assign out_vc    = offer ? grant : '0;
  assign out_tail  = offer && head[FLIT_W];
  assign out_data  = offer ? head[FLIT_W-1:0] : '0;

  // Input decode; a full FIFO still accepts when it dequeues this cycle
  always_comb begin
    in_idx = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (in_vc[v]) in_idx = VCW'(v);
    end
    vc_onehot     = (in_vc != '0) && ((in_vc & (in_vc - NUM_VCS'(1))) == '0);
    enq_ok        = in_valid && vc_onehot && (!full[in_idx] || (xfer && (grant == in_idx)));
    enq_drop_full = in_valid && vc_onehot && !enq_ok;
  end

  // Pointer and occupancy updates
  always_comb begin
    enq_v = '0;
    deq_v = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      enq_v[v]  = enq_ok && (in_idx == VCW'(v));
      deq_v[v]  = xfer && (grant == VCW'(v));
      wptr_d[v] = enq_v[v] ? wptr_q[v] + PW'(1) : wptr_q[v];
      rptr_d[v] = deq_v[v] ? rptr_q[v] + PW'(1) : rptr_q[v];
      cnt_d[v]  = cnt_q[v] + CW'(enq_v[v]) - CW'(deq_v[v]);
    end
  end

  // Credit return and sticky errors
  always_comb begin
    credit_valid_d = xfer;
    credit_vc_d    = xfer ? grant : '0;
    err_overflow_d = err_overflow_q || enq_drop_full;
    err_vc_d       = err_vc_q || (in_valid && !vc_onehot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= VCW'(NUM_VCS - 1);
      lock_vc_q      <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      err_overflow_q <= 1'b0;
      err_vc_q       <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
        cnt_q[v]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_vc_q      <= lock_vc_d;
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      err_overflow_q <= err_overflow_d;
      err_vc_q       <= err_vc_d;
      for (int v = 0; v < NUM_VCS; v++) begin
        wptr_q[v] <= wptr_d[v];
        rptr_q[v] <= rptr_d[v];
        cnt_q[v]  <= cnt_d[v];
      end
    end
  end

  // Flit storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[in_idx][wptr_q[in_idx]] <= {in_tail, in_data};
  end

  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;
  assign err_overflow = err_overflow_q;
  assign err_vc       = err_vc_q;

`ifdef NL_EJECT_STATS_EN
  logic [31:0] pkt_count_q [NUM_VCS];
  logic [31:0] pkt_count_d [NUM_VCS];
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] bubble_cycles_q, bubble_cycles_d;

  // Statistics counters, free-running and wrapping
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      pkt_count_d[v] = pkt_count_q[v] + 32'(deq_v[v] && head[FLIT_W]);
    end
    stall_cycles_d  = stall_cycles_q + 32'(offer && !out_ready);
    bubble_cycles_d = bubble_cycles_q + 32'((state_q == LOCKED) && !nonempty[lock_vc_q]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) pkt_count_q[v] <= '0;
      stall_cycles_q  <= '0;
      bubble_cycles_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) pkt_count_q[v] <= pkt_count_d[v];
      stall_cycles_q  <= stall_cycles_d;
      bubble_cycles_q <= bubble_cycles_d;
    end
  end

  assign pkt_count     = pkt_count_q;
  assign stall_cycles  = stall_cycles_q;
  assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_nl_eject_vc_scheduler.sv
// Directed bench for nl_eject_vc_scheduler (NUM_VCS=2, FLIT_W=64, BUF_DEPTH=4).
module tb_nl_eject_vc_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic        in_tail;
  logic [63:0] in_data;
  logic        credit_valid;
  logic [0:0]  credit_vc;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_vc;
  logic        out_tail;
  logic [63:0] out_data;
  logic        err_overflow;
  logic        err_vc;

  int tests = 0;
  int fails = 0;

  nl_eject_vc_scheduler #(.NUM_VCS(2), .FLIT_W(64), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_vc(in_vc), .in_tail(in_tail), .in_data(in_data),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .out_valid(out_valid), .out_ready(out_ready), .out_vc(out_vc),
    .out_tail(out_tail), .out_data(out_data),
    .err_overflow(err_overflow), .err_vc(err_vc)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] vc, input logic t, input logic [63:0] d);
    in_valid = v; in_vc = vc; in_tail = t; in_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; drive(1'b0, 2'b00, 1'b0, 64'h0);
    step(); step();
    rst = 1'b0;
    tests++;
    if ({out_valid, out_vc, out_tail, out_data} !== 67'h0) begin
      fails++; $display("FAIL reset_out: got v=%0b vc=%0d t=%0b d=%h, want all 0", out_valid, out_vc, out_tail, out_data);
    end
    tests++;
    if ({credit_valid, credit_vc, err_overflow, err_vc} !== 4'h0) begin
      fails++; $display("FAIL reset_misc: got cv=%0b cvc=%0d eo=%0b ev=%0b, want 0", credit_valid, credit_vc, err_overflow, err_vc);
    end
  endtask

  task automatic test_single_flit();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 1'b1, 64'hA0);
    step();
    drive(1'b1, 2'b10, 1'b1, 64'hB1);
    tests++;
    if ({out_valid, out_vc, out_data} !== {1'b1, 1'b0, 64'hA0} || credit_valid !== 1'b0) begin
      fails++; $display("FAIL single_vc0: got v=%0b vc=%0d d=%h cv=%0b, want 1 0 a0 0", out_valid, out_vc, out_data, credit_valid);
    end
    step();
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    tests++;
    if ({out_valid, out_vc, out_data} !== {1'b1, 1'b1, 64'hB1}) begin
      fails++; $display("FAIL single_vc1: got v=%0b vc=%0d d=%h, want 1 1 b1", out_valid, out_vc, out_data);
    end
    tests++;
    if ({credit_valid, credit_vc} !== 2'b10) begin
      fails++; $display("FAIL single_credit0: got cv=%0b cvc=%0d, want 1 0", credit_valid, credit_vc);
    end
    step();
    tests++;
    if ({out_valid, credit_valid, credit_vc} !== 3'b011) begin
      fails++; $display("FAIL single_credit1: got v=%0b cv=%0b cvc=%0d, want 0 1 1", out_valid, credit_valid, credit_vc);
    end
    step();
    tests++;
    if (credit_valid !== 1'b0) begin
      fails++; $display("FAIL single_credit_idle: got cv=%0b, want 0", credit_valid);
    end
  endtask

  task automatic test_wormhole();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 1'b0, 64'hC0);
    step();
    drive(1'b1, 2'b10, 1'b1, 64'hD0);
    tests++;
    if ({out_valid, out_vc, out_tail, out_data} !== {1'b1, 1'b0, 1'b0, 64'hC0}) begin
      fails++; $display("FAIL worm_head: got v=%0b vc=%0d t=%0b d=%h, want 1 0 0 c0", out_valid, out_vc, out_tail, out_data);
    end
    step();
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    tests++;
    if (out_valid !== 1'b0 || {credit_valid, credit_vc} !== 2'b10) begin
      fails++; $display("FAIL worm_bubble1: got v=%0b cv=%0b cvc=%0d, want 0 1 0", out_valid, credit_valid, credit_vc);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL worm_bubble2: got v=%0b, want 0", out_valid);
    end
    drive(1'b1, 2'b01, 1'b0, 64'hC1);
    step();
    drive(1'b1, 2'b01, 1'b1, 64'hC2);
    tests++;
    if ({out_valid, out_vc, out_tail, out_data} !== {1'b1, 1'b0, 1'b0, 64'hC1}) begin
      fails++; $display("FAIL worm_body: got v=%0b vc=%0d t=%0b d=%h, want 1 0 0 c1", out_valid, out_vc, out_tail, out_data);
    end
    step();
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    tests++;
    if ({out_valid, out_vc, out_tail, out_data} !== {1'b1, 1'b0, 1'b1, 64'hC2}) begin
      fails++; $display("FAIL worm_tail: got v=%0b vc=%0d t=%0b d=%h, want 1 0 1 c2", out_valid, out_vc, out_tail, out_data);
    end
    step();
    tests++;
    if ({out_valid, out_vc, out_data} !== {1'b1, 1'b1, 64'hD0}) begin
      fails++; $display("FAIL worm_then_vc1: got v=%0b vc=%0d d=%h, want 1 1 d0", out_valid, out_vc, out_data);
    end
    step();
    tests++;
    if ({out_valid, credit_valid, credit_vc} !== 3'b011) begin
      fails++; $display("FAIL worm_end: got v=%0b cv=%0b cvc=%0d, want 0 1 1", out_valid, credit_valid, credit_vc);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 1'b1, 64'hE1);
    step();
    drive(1'b1, 2'b01, 1'b1, 64'hE0);
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({out_valid, out_vc, out_data, credit_valid} !== {1'b1, 1'b1, 64'hE1, 1'b0}) begin
        fails++; $display("FAIL bp_stable[%0d]: got v=%0b vc=%0d d=%h cv=%0b, want 1 1 e1 0", k, out_valid, out_vc, out_data, credit_valid);
      end
      step();
      drive(1'b0, 2'b00, 1'b0, 64'h0);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if ({out_valid, out_vc, out_data, credit_valid, credit_vc} !== {1'b1, 1'b0, 64'hE0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL bp_release: got v=%0b vc=%0d d=%h cv=%0b cvc=%0d, want 1 0 e0 1 1", out_valid, out_vc, out_data, credit_valid, credit_vc);
    end
    step();
    tests++;
    if ({out_valid, credit_valid, credit_vc} !== 3'b010) begin
      fails++; $display("FAIL bp_drain: got v=%0b cv=%0b cvc=%0d, want 0 1 0", out_valid, credit_valid, credit_vc);
    end
    step();
  endtask

  task automatic test_full_deq();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b01, 1'b1, 64'hF0 + 64'(k));
      step();
    end
    // Full FIFO, dequeue and enqueue on the same VC in one cycle
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 1'b1, 64'hF4);
    tests++;
    if ({out_valid, out_data} !== {1'b1, 64'hF0}) begin
      fails++; $display("FAIL fd_head: got v=%0b d=%h, want 1 f0", out_valid, out_data);
    end
    step();
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    tests++;
    if (err_overflow !== 1'b0) begin
      fails++; $display("FAIL fd_no_err: got eo=%0b, want 0", err_overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if ({out_valid, out_data} !== {1'b1, 64'hF0 + 64'(k)}) begin
        fails++; $display("FAIL fd_drain[%0d]: got v=%0b d=%h, want 1 %h", k, out_valid, out_data, 64'hF0 + 64'(k));
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b0 || err_overflow !== 1'b0) begin
      fails++; $display("FAIL fd_empty: got v=%0b eo=%0b, want 0 0", out_valid, err_overflow);
    end
    step();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b01, 1'b1, 64'h100 + 64'(k));
      step();
      if (k == 3) begin
        tests++;
        if (err_overflow !== 1'b0) begin
          fails++; $display("FAIL ovf_early: got eo=%0b, want 0", err_overflow);
        end
      end
    end
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    tests++;
    if (err_overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_set: got eo=%0b, want 1", err_overflow);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({out_valid, out_data} !== {1'b1, 64'h100 + 64'(k)}) begin
        fails++; $display("FAIL ovf_out[%0d]: got v=%0b d=%h, want 1 %h", k, out_valid, out_data, 64'h100 + 64'(k));
      end
      step();
      tests++;
      if ({credit_valid, credit_vc} !== 2'b10) begin
        fails++; $display("FAIL ovf_credit[%0d]: got cv=%0b cvc=%0d, want 1 0", k, credit_valid, credit_vc);
      end
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL ovf_only4: got v=%0b, want 0", out_valid);
    end
    step();
    tests++;
    if (credit_valid !== 1'b0 || err_overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky: got cv=%0b eo=%0b, want 0 1", credit_valid, err_overflow);
    end
  endtask

  task automatic test_bad_vc();
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 1'b1, 64'hBAD);
    step();
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    tests++;
    if ({err_vc, out_valid} !== 2'b10) begin
      fails++; $display("FAIL badvc: got ev=%0b v=%0b, want 1 0", err_vc, out_valid);
    end
    step();
    tests++;
    if ({err_vc, out_valid, credit_valid} !== 3'b100) begin
      fails++; $display("FAIL badvc_sticky: got ev=%0b v=%0b cv=%0b, want 1 0 0", err_vc, out_valid, credit_valid);
    end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 1'b0, 64'h200);
    step();
    drive(1'b1, 2'b10, 1'b0, 64'h201);
    step();
    out_ready = 1'b1;
    step();
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({out_valid, out_vc, out_tail, out_data, credit_valid, credit_vc, err_overflow, err_vc} !== 71'h0) begin
      fails++; $display("FAIL rst_mid: got v=%0b vc=%0d d=%h cv=%0b eo=%0b ev=%0b, want all 0", out_valid, out_vc, out_data, credit_valid, err_overflow, err_vc);
    end
    drive(1'b1, 2'b10, 1'b1, 64'h300);
    step();
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    tests++;
    if ({out_valid, out_vc, out_tail, out_data} !== {1'b1, 1'b1, 1'b1, 64'h300}) begin
      fails++; $display("FAIL rst_next_pkt: got v=%0b vc=%0d t=%0b d=%h, want 1 1 1 300", out_valid, out_vc, out_tail, out_data);
    end
    step();
    tests++;
    if ({out_valid, credit_valid, credit_vc} !== 3'b011) begin
      fails++; $display("FAIL rst_next_credit: got v=%0b cv=%0b cvc=%0d, want 0 1 1", out_valid, credit_valid, credit_vc);
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 64'h0);
    test_reset();
    test_single_flit();
    test_wormhole();
    test_backpressure();
    test_full_deq();
    test_overflow();
    test_bad_vc();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nl_eject_vc_scheduler.md
Name: nl_eject_vc_scheduler

Overview:
- Sits between a router's local exit port and the node's traffic sink / network interface.
- Buffers flits per exit VC and arbitrates the single ejection channel among VCs, round-robin, packet-atomic (wormhole lock from head to tail).
- Returns one credit per dequeued flit to the router exit so upstream VC flow control stays exact.

Parameters:
- NUM_VCS, 2, number of exit VCs (2..8)
- FLIT_W, 64, opaque flit payload width in bits
- BUF_DEPTH, 4, per-VC FIFO depth in flits (power of 2, >=2); matches the router exit credit count

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  flit arriving from router exit
- in_vc  in  NUM_VCS  one-hot VC id of arriving flit
- in_tail  in  1  arriving flit is tail
- in_data  in  FLIT_W  arriving flit payload
- credit_valid  out  1  credit return strobe to router
- credit_vc  out  $clog2(NUM_VCS)  binary VC id of returned credit
- out_valid  out  1  flit offered to sink
- out_ready  in  1  sink accepts flit
- out_vc  out  $clog2(NUM_VCS)  binary VC of offered flit
- out_tail  out  1  offered flit is tail
- out_data  out  FLIT_W  offered payload
- err_overflow  out  1  sticky: flit arrived at a full VC FIFO
- err_vc  out  1  sticky: in_valid with in_vc not one-hot

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset value of every output:
  - credit_valid=0, credit_vc=0, out_valid=0, out_vc=0, out_tail=0, out_data=0.
  - err_overflow=0, err_vc=0.
  - All FIFOs empty, state IDLE, rr_ptr=NUM_VCS-1.
- Reset mid-packet:
  - Flushes all buffered flits; no credits are returned for them.
  - The router is reset in the same cycle.
- Enqueue:
  - in_valid with one-hot in_vc writes {in_tail, in_data} into that VC's FIFO at the clock edge.
  - Enqueue to dequeue visibility is 1 cycle: a flit written at edge N may be offered after edge N.
- Bad VC id: in_valid with in_vc zero or multi-hot drops the flit, sets err_vc, and returns no credit.
- Full FIFO:
  - in_valid to a full FIFO drops the flit and sets err_overflow.
  - Exception: if the same VC dequeues in the same cycle, the enqueue succeeds and the count is unchanged.
- Dequeue handshake:
  - A flit transfers when out_valid && out_ready.
  - out_vc, out_tail and out_data come from the granted VC's FIFO head, combinationally.
- Credit return:
  - Registered, fixed 1-cycle latency: a transfer at edge N gives credit_valid=1 and credit_vc=granted VC for the cycle after edge N.
  - At most one credit per cycle; there are no other credit sources.
- State machine:
  - IDLE:
    - grant = first non-empty VC strictly after rr_ptr in cyclic order.
    - out_valid = any VC non-empty.
    - Transfer with tail: rr_ptr <= grant, stay IDLE.
    - Transfer without tail, or out_valid && !out_ready: lock_vc <= grant, go to LOCKED.
  - LOCKED:
    - grant = lock_vc.
    - out_valid = FIFO[lock_vc] non-empty. Other VCs are never offered, even if the locked FIFO is empty (wormhole bubble).
    - Tail transfer: rr_ptr <= lock_vc, go to IDLE.
  - An offered flit never changes VC or payload until accepted (stable-offer rule).
- Single-flit packets (head = tail) transfer in IDLE without entering LOCKED.
- Arbitration sees only FIFO state at the start of the cycle; same-cycle enqueues are not visible.
- Counters:
  - Per-VC FIFO pointers are $clog2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH.
  - Occupancy count is $clog2(BUF_DEPTH)+1 bits and saturates at neither end (overflow is prevented by the drop rule).
- Fairness: any non-empty VC is granted within (NUM_VCS-1) packets.

Optional Feature:
- Macro: NL_EJECT_STATS_EN.
- When defined, adds these outputs:
  - pkt_count [NUM_VCS][31:0]: tails transferred per VC.
  - stall_cycles [31:0]: cycles with out_valid && !out_ready.
  - bubble_cycles [31:0]: cycles in LOCKED with the locked FIFO empty.
- All three counters clear on rst and wrap at 2^32.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Single-flit packets, reset then out_ready=1: VC0 pkt at cycle 1, VC1 pkt at cycle 1 -> out_vc=0 at cycle 2, out_vc=1 at cycle 3; credit_vc=0 at cycle 3 and credit_vc=1 at cycle 4.
- Wormhole lock: VC0 3-flit packet with flit 2 delayed 2 cycles, VC1 1-flit packet present throughout -> VC0 flits 1..3 delivered contiguously, 2 bubble cycles with out_valid=0, then VC1; rr_ptr ends at 1.
- Backpressure: out_ready=0 for 5 cycles with VC1 head offered, then VC0 filled -> out_vc stays 1 and out_data is stable for all 5 cycles; no credit until accepted.
- Overflow, BUF_DEPTH=4, out_ready=0: 5 flits to VC0 -> 5th dropped, err_overflow=1 sticky; after release exactly 4 flits out and 4 credits.
- Full plus simultaneous dequeue: VC0 full, out_ready=1 and in_valid to VC0 same cycle -> no error, occupancy stays 4.
- Bad VC and reset: in_vc=2'b11 -> err_vc=1, no enqueue; rst mid-packet -> all outputs 0, errors cleared, next packet on any VC accepted from IDLE.
